// File: rtl/pipelined_adder_tree.sv
// N-lane adder tree, one register per tree level; latency LEVELS cycles, II = 1.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready combinationally.
module pipelined_adder_tree #(
  parameter int N_INPUTS = 4,
  parameter int IN_WIDTH = 8,
  parameter int SIGNED   = 0,
  localparam int LEVELS  = $clog2(N_INPUTS),
  localparam int OUT_W   = IN_WIDTH + LEVELS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_sum
);

  logic              stall;
  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] vld_d;

  assign stall     = vld_q[LEVELS-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[LEVELS-1];

  always_comb begin
    vld_d = vld_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      for (int k = 1; k < LEVELS; k++) begin
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Stage k registers the nodes of tree level k+1, each one bit wider than its operands.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NODES = N_INPUTS >> (k + 1);
    localparam int WI    = IN_WIDTH + k;
    localparam int WO    = WI + 1;

    logic [WI-1:0] opnd   [2*NODES];
    logic [WO-1:0] node_d [NODES];
    logic [WO-1:0] node_q [NODES];
    logic          load;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < 2*NODES; i++) begin : g_lane
        assign opnd[i] = in_data[i*IN_WIDTH +: IN_WIDTH];
      end
      assign load = in_valid & ~stall;
    end else begin : g_src
      for (genvar i = 0; i < 2*NODES; i++) begin : g_lane
        assign opnd[i] = g_lvl[k-1].node_q[i];
      end
      assign load = vld_q[k-1] & ~stall;
    end

    for (genvar j = 0; j < NODES; j++) begin : g_node
      if (SIGNED != 0) begin : g_sx
        assign node_d[j] = {opnd[2*j][WI-1], opnd[2*j]} + {opnd[2*j+1][WI-1], opnd[2*j+1]};
      end else begin : g_zx
        assign node_d[j] = {1'b0, opnd[2*j]} + {1'b0, opnd[2*j+1]};
      end
    end

    // Bubbles leave the data untouched so out_sum keeps the last valid result.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 0; j < NODES; j++) begin
          node_q[j] <= '0;
        end
      end else if (load) begin
        for (int j = 0; j < NODES; j++) begin
          node_q[j] <= node_d[j];
        end
      end
    end
  end

  assign out_sum = g_lvl[LEVELS-1].node_q[0];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for three tree configurations: 4x8 unsigned, 4x8 signed, 8x4 unsigned.
module tb_pipelined_adder_tree;

  typedef struct {
    logic [15:0] sum;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic        a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id;
  logic [9:0]  a_sum;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id;
  logic [9:0]  b_sum;
  logic        c_iv, c_ir, c_ov, c_or;
  logic [31:0] c_id;
  logic [6:0]  c_sum;

  pipelined_adder_tree #(.N_INPUTS(4), .IN_WIDTH(8), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum));

  pipelined_adder_tree #(.N_INPUTS(4), .IN_WIDTH(8), .SIGNED(1)) u_sdut (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum));

  pipelined_adder_tree #(.N_INPUTS(8), .IN_WIDTH(4), .SIGNED(0)) u_wdut (
    .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_sum(c_sum));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rdy(input int d);
    case (d)
      0:       return a_ir;
      1:       return b_ir;
      default: return c_ir;
    endcase
  endfunction

  // Issue one vector, holding it until accepted; lat=1 also pins the expected output cycle.
  task automatic send(input int d, input logic [31:0] data, input logic [15:0] sum, input bit lat);
    int   n;
    exp_t e;
    @(negedge clk);
    case (d)
      0:       begin a_iv = 1'b1; a_id = data; end
      1:       begin b_iv = 1'b1; b_id = data; end
      default: begin c_iv = 1'b1; c_id = data; end
    endcase
    #1;
    n = 0;
    while (!rdy(d) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut=%0d actual=in_ready_low required=accepted", d);
    end
    e.sum = sum;
    e.due = lat ? cyc + ((d == 2) ? 3 : 2) : -1;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drop();
    @(negedge clk);
    a_iv = 1'b0;
    b_iv = 1'b0;
    c_iv = 1'b0;
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [15:0] s);
    exp_t e;
    bit   empty;
    if (v && r) begin
      case (d)
        0:       empty = (q0.size() == 0);
        1:       empty = (q1.size() == 0);
        default: empty = (q2.size() == 0);
      endcase
      if (empty) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output dut=%0d actual=0x%0h required=no_output", d, s);
      end else begin
        case (d)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("sum_dut%0d", d), {16'h0, s}, {16'h0, e.sum});
        if (e.due >= 0) chk($sformatf("latency_dut%0d", d), cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon(0, a_ov, a_or, {6'h0, a_sum});
    mon(1, b_ov, b_or, {6'h0, b_sum});
    mon(2, c_ov, c_or, {9'h0, c_sum});
  end

  initial begin
    int n;
    reset = 1'b1;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    a_id = '0;   b_id = '0;   c_id = '0;
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_out_valid", {31'h0, a_ov}, 32'h0);
    chk("reset_out_sum", {22'h0, a_sum}, 32'h0);
    chk("reset_in_ready", {31'h0, a_ir}, 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Latency and extremes
    send(0, 32'hFF010300, 16'd259, 1'b1);
    drop();
    repeat (3) @(negedge clk);
    send(0, 32'hFFFFFFFF, 16'h3FC, 1'b1);
    send(0, 32'h00000000, 16'h000, 1'b1);
    drop();
    repeat (3) @(negedge clk);

    // Back-to-back throughput
    send(0, 32'h04030201, 16'd10, 1'b1);
    send(0, 32'h281E140A, 16'd100, 1'b1);
    send(0, 32'h0100FFFF, 16'd511, 1'b1);
    send(0, 32'h10204080, 16'd240, 1'b1);
    drop();
    repeat (4) @(negedge clk);

    // Backpressure with two vectors in flight
    a_or = 1'b0;
    send(0, 32'h64646464, 16'h190, 1'b0);
    send(0, 32'h0A090807, 16'h022, 1'b0);
    drop();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'h0, a_ir}, 32'h0);
      chk("stall_out_valid", {31'h0, a_ov}, 32'h1);
      chk("stall_out_sum", {22'h0, a_sum}, 32'h190);
      @(negedge clk);
    end
    a_or = 1'b1;
    repeat (4) @(negedge clk);

    // Reset with two vectors in flight
    send(0, 32'h01010101, 16'd4, 1'b1);
    send(0, 32'h02020202, 16'd8, 1'b1);
    @(negedge clk);
    a_iv = 1'b0;
    reset = 1'b1;
    q0.delete();
    #1;
    chk("midreset_out_valid", {31'h0, a_ov}, 32'h0);
    chk("midreset_out_sum", {22'h0, a_sum}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("post_reset_no_stale", {31'h0, a_ov}, 32'h0);

    // Signed lanes
    send(1, 32'h80808080, 16'h200, 1'b1);
    send(1, 32'h7FFFFF7F, 16'h0FC, 1'b1);
    drop();

    // Eight 4-bit lanes, three levels
    send(2, 32'hFFFFFFFF, 16'd120, 1'b1);
    drop();

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
